max_serial_argmax: RTL and testbench

- Sequential counterpart of the combinational max-reduction tree: accepts one Q-value per cycle over a valid/ready stream.
- Tracks the running maximum and the channel index where it occurred.
- After CHANNELS samples, presents {max value, argmax index} on an output valid/ready handshake.
- Sits between the Q-table read port and the action-selection / Q-update logic. The Q-update path uses the max; the action selector uses the index.

---
 rtl/max_serial_argmax.sv | 217 +++++++++++++++++++++
 tb/tb_max_serial_argmax.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/max_serial_argmax.sv
// -----------------------------------------------------------------------------
// max_serial_argmax
//
// Serial max/argmax search over CHANNELS fp32 Q-values. After an i_start pulse
// in IDLE, the block takes one sample per accepted valid/ready beat and keeps
// the running maximum and the arrival index (0-based) where it occurred. After
// CHANNELS accepts it presents {o_max, o_index} on an output valid/ready
// handshake. It then returns to IDLE when the result is taken.
//
// Optional feature:
//   MAX_ARGMAX_TIE_LAST_EN - when defined, a later sample equal to the running
//   max replaces it, so ties select the latest index. +0 and -0 count as equal.
//   When undefined, the replacement is strict and the earliest index wins.
//
// Ports:
//   i_clk    in   clock, rising edge
//   i_rst_n  in   asynchronous active-low reset
//   i_start  in   begins a new search, honoured only in IDLE
//   i_valid  in   input sample valid
//   i_data   in   input Q-value (fp32 bit pattern)
//   o_ready  out  a sample can be accepted this cycle (COLLECT)
//   o_valid  out  result valid (DONE)
//   i_ready  in   downstream accepts the result
//   o_max    out  maximum Q-value of the last search
//   o_index  out  arrival index of the maximum
//   o_busy   out  high in COLLECT or DONE
// -----------------------------------------------------------------------------
module max_serial_argmax #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_WIDTH = $clog2(CHANNELS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_max,
  output logic [IDX_WIDTH-1:0]  o_index,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHANNELS - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ZERO = {IDX_WIDTH{1'b0}};
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-2:0] MAG_ZERO = {(DATA_WIDTH-1){1'b0}};

  state_t                 state_r;
  state_t                 state_s;
  logic [IDX_WIDTH-1:0]   count_r;
  logic [DATA_WIDTH-1:0]  max_r;
  logic [IDX_WIDTH-1:0]   index_r;
  logic                   ready_r;
  logic                   valid_r;
  logic                   busy_r;
  logic                   ready_s;
  logic                   valid_s;
  logic                   busy_s;
  logic                   accept_s;
  logic                   last_s;
  logic                   replace_s;

  // a > b on raw fp32 bit patterns: sign-magnitude order, +0 == -0.
  function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
    logic                  sa;
    logic                  sb;
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    if (sa != sb) begin
      if ((ma == MAG_ZERO) && (mb == MAG_ZERO)) begin
        fp_gt = 1'b0;
      end else begin
        fp_gt = ~sa;
      end
    end else if (!sa) begin
      fp_gt = (ma > mb);
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      fp_gt = (ma < mb);
    end
  endfunction

`ifdef MAX_ARGMAX_TIE_LAST_EN
  // a == b on raw fp32 bit patterns, treating the two zeros as equal.
  function automatic logic fp_eq(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
    fp_eq = (a == b) ||
            ((a[DATA_WIDTH-2:0] == MAG_ZERO) && (b[DATA_WIDTH-2:0] == MAG_ZERO));
  endfunction

  assign replace_s = fp_gt(i_data, max_r) || fp_eq(i_data, max_r);
`else
  assign replace_s = fp_gt(i_data, max_r);
`endif

  // ready_r is high exactly in COLLECT, so it doubles as the state qualifier.
  assign accept_s = i_valid && ready_r;
  assign last_s   = (count_r == LAST_IDX);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and next values of the registered status outputs.
  always_comb begin
    state_s = state_r;
    ready_s = 1'b0;
    valid_s = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_s = ST_COLLECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (accept_s && last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_DONE: begin
        if (valid_r && i_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Status flags are decoded from the next state so they line up with it.
    case (state_s)
      ST_COLLECT: begin
        ready_s = 1'b1;
        busy_s  = 1'b1;
      end
      ST_DONE: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ready_r <= ready_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
    end
  end

  // Sample counter and running max/argmax; results persist after DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r <= IDX_ZERO;
      max_r   <= {DATA_WIDTH{1'b0}};
      index_r <= IDX_ZERO;
    end else begin
      if ((state_r == ST_IDLE) && i_start) begin
        count_r <= IDX_ZERO;
      end else if (accept_s) begin
        if (last_s) begin
          count_r <= IDX_ZERO;
        end else begin
          count_r <= count_r + IDX_ONE;
        end
      end
      // The first sample of a search loads unconditionally, dropping the
      // previous search's result.
      if (accept_s && ((count_r == IDX_ZERO) || replace_s)) begin
        max_r   <= i_data;
        index_r <= count_r;
      end
    end
  end

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_busy  = busy_r;
  assign o_max   = max_r;
  assign o_index = index_r;

endmodule

// File: tb/tb_max_serial_argmax.sv
// -----------------------------------------------------------------------------
// Bench for max_serial_argmax: directed searches with hand-computed results.
// The stimulus side pushes the expected {max, index} into a queue; a monitor
// thread compares every cycle the DUT shows o_valid and pops on handshake.
// Build with +define+MAX_ARGMAX_TIE_LAST_EN to check the tie-last variant.
// -----------------------------------------------------------------------------
module tb_max_serial_argmax;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_max;
  logic [IW-1:0] o_index;
  logic          o_busy;

  logic [DW+IW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  max_serial_argmax #(.CHANNELS(CH), .DATA_WIDTH(DW)) dut (
    .i_clk  (clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_valid(i_valid),
    .i_data (i_data),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_max  (o_max),
    .o_index(o_index),
    .o_busy (o_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got max=0x%0h index=%0d with nothing expected",
                   o_max, o_index);
        end else begin
          check("result", 64'({o_max, o_index}), 64'(exp_q[0]));
          if (i_ready === 1'b1) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ready"}, 64'(o_ready), 64'(1'b0));
    check({name, "_valid"}, 64'(o_valid), 64'(1'b0));
    check({name, "_busy"},  64'(o_busy),  64'(1'b0));
  endtask

  // One full search: start, samples under valid pattern pat (bit c = cycle c),
  // optional i_start pulse mid-collection, then hold cycles of i_ready=0.
  task automatic run_search(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                            input logic [DW-1:0] emax, input logic [IW-1:0] eidx,
                            input logic [7:0] pat, input int plen,
                            input bit start_mid, input int hold);
    logic [DW-1:0] dd[4];
    int k;
    dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
    k = 0;
    i_ready = (hold == 0);
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    check("ready_in_collect", 64'(o_ready), 64'(1'b1));
    exp_q.push_back({emax, eidx});
    for (int c = 0; c < plen; c++) begin
      i_valid = pat[c];
      i_data  = (k < 4) ? dd[k] : 32'h0000_0000;
      i_start = start_mid && (c == 2);
      @(posedge clk); #1;
      if (pat[c]) k++;
      if (c == plen - 2) check("not_done_early", 64'(o_valid), 64'(1'b0));
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    check("valid_latency", 64'(o_valid), 64'(1'b1));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check("valid_held", 64'(o_valid), 64'(1'b1));
    end
    if (hold > 0) begin
      @(posedge clk); #1 i_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_idle_outputs("back_to_idle");
    check("result_kept_in_idle", 64'({o_max, o_index}), 64'({emax, eidx}));
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_data  = 32'h0000_0000;
    i_ready = 1'b1;
    fork
      monitor();
    join_none

    #2 i_rst_n = 1'b0;
    #1;
    check_idle_outputs("reset");
    check("reset_max_index", 64'({o_max, o_index}), 64'd0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;

    // 1.0, 2.0, 0.5, -1.0 with a 5-cycle hold.
    run_search(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000,
               32'h4000_0000, 2'd1, 8'b0000_1111, 4, 1'b0, 5);
    // All negative: -3, -1, -3, -3.
    run_search(32'hC040_0000, 32'hBF80_0000, 32'hC040_0000, 32'hC040_0000,
               32'hBF80_0000, 2'd1, 8'b0000_1111, 4, 1'b0, 0);
`ifdef MAX_ARGMAX_TIE_LAST_EN
    run_search(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F00_0000,
               32'h4000_0000, 2'd2, 8'b0000_1111, 4, 1'b0, 0);
    run_search(32'h0000_0000, 32'h8000_0000, 32'hBF00_0000, 32'hBF00_0000,
               32'h8000_0000, 2'd1, 8'b0000_1111, 4, 1'b0, 0);
    run_search(32'h0000_0000, 32'h8000_0000, 32'h3F00_0000, 32'h3F00_0000,
               32'h3F00_0000, 2'd3, 8'b0000_1111, 4, 1'b0, 0);
`else
    run_search(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F00_0000,
               32'h4000_0000, 2'd1, 8'b0000_1111, 4, 1'b0, 0);
    run_search(32'h0000_0000, 32'h8000_0000, 32'hBF00_0000, 32'hBF00_0000,
               32'h0000_0000, 2'd0, 8'b0000_1111, 4, 1'b0, 0);
    run_search(32'h0000_0000, 32'h8000_0000, 32'h3F00_0000, 32'h3F00_0000,
               32'h3F00_0000, 2'd2, 8'b0000_1111, 4, 1'b0, 0);
`endif
    // Bubbles 1,0,0,1,1,0,1, i_start pulsed mid-collection, 5-cycle hold.
    run_search(32'h3F00_0000, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000,
               32'h4040_0000, 2'd1, 8'b0101_1001, 7, 1'b1, 5);

    // Reset after two accepts of large values; the partial search must vanish.
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    i_valid = 1'b1; i_data = 32'h40A0_0000;
    @(posedge clk); #1 i_data = 32'h40E0_0000;
    @(posedge clk); #1 i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    check("mid_reset_max_index", 64'({o_max, o_index}), 64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    run_search(32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3F00_0000,
               32'h3F80_0000, 2'd2, 8'b0000_1111, 4, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
